// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
//
// Shares the board SDRAM between three single-word clients and the periodic
// auto-refresh. Exactly one transaction is in flight at a time.
// Grant priority in IDLE: pending refresh, then client 0, then clients 1/2
// in round-robin order.
//
// Handshakes:
//   cN_req  is raised by the client and held until its one-cycle cN_done.
//   mem_req is raised by the arbiter and held, with all mem_* outputs stable,
//   until the sequencer returns a one-cycle mem_done.
//
// Ports:
//   m_clock, RESET_N     clock, asynchronous active-low reset
//   cN_req/we/addr/      client N request, write flag, word address,
//   wdata/be             write data, byte enables {upper, lower}
//   cN_done              one-cycle completion pulse to client N
//   rdata                last read word; valid while a read's cN_done is high
//   mem_req/refresh/we/  command to the SDRAM sequencer (refresh qualifies
//   addr/wdata/be        mem_req as an auto-refresh)
//   mem_done, mem_rdata  completion pulse and read data from the sequencer
//   refresh_miss         sticky: a refresh interval expired while the
//                        previous refresh was still waiting
// -----------------------------------------------------------------------------
module sdram_arbiter #(
    parameter int REFRESH_INTERVAL = 390,
    parameter int ADDR_W           = 24
) (
    input  logic              m_clock,
    input  logic              RESET_N,
    input  logic              c0_req,
    input  logic              c0_we,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [15:0]       c0_wdata,
    input  logic [1:0]        c0_be,
    output logic              c0_done,
    input  logic              c1_req,
    input  logic              c1_we,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [15:0]       c1_wdata,
    input  logic [1:0]        c1_be,
    output logic              c1_done,
    input  logic              c2_req,
    input  logic              c2_we,
    input  logic [ADDR_W-1:0] c2_addr,
    input  logic [15:0]       c2_wdata,
    input  logic [1:0]        c2_be,
    output logic              c2_done,
    output logic [15:0]       rdata,
    output logic              mem_req,
    output logic              mem_refresh,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [1:0]        mem_be,
    input  logic              mem_done,
    input  logic [15:0]       mem_rdata,
    output logic              refresh_miss
);

    localparam int TW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_XFER    = 2'd1,
        S_REFRESH = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              pend_q, pend_d;
    logic              miss_q, miss_d;
    logic [1:0]        rr_last_q, rr_last_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_refresh_q, mem_refresh_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       mem_wdata_q, mem_wdata_d;
    logic [1:0]        mem_be_q, mem_be_d;
    logic [15:0]       rdata_q, rdata_d;

    logic              wrap;
    logic              refresh_grant;
    logic              any_req;
    logic [1:0]        sel;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [15:0]       sel_wdata;
    logic [1:0]        sel_be;

    assign wrap    = (timer_q == TW'(REFRESH_INTERVAL - 1));
    assign timer_d = wrap ? '0 : timer_q + TW'(1);
    assign any_req = c0_req | c1_req | c2_req;

    // Client selection; only meaningful when any_req is set. On a 1/2 tie the
    // client that was not granted last wins.
    always_comb begin
        sel = 2'd0;
        if (c0_req) begin
            sel = 2'd0;
        end else if (c1_req && c2_req) begin
            sel = (rr_last_q == 2'd1) ? 2'd2 : 2'd1;
        end else if (c1_req) begin
            sel = 2'd1;
        end else begin
            sel = 2'd2;
        end

        sel_we    = c0_we;
        sel_addr  = c0_addr;
        sel_wdata = c0_wdata;
        sel_be    = c0_be;
        case (sel)
            2'd1: begin
                sel_we    = c1_we;
                sel_addr  = c1_addr;
                sel_wdata = c1_wdata;
                sel_be    = c1_be;
            end
            2'd2: begin
                sel_we    = c2_we;
                sel_addr  = c2_addr;
                sel_wdata = c2_wdata;
                sel_be    = c2_be;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        rr_last_d     = rr_last_q;
        mem_req_d     = mem_req_q;
        mem_refresh_d = mem_refresh_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_be_d      = mem_be_q;
        rdata_d       = rdata_q;
        refresh_grant = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    refresh_grant = 1'b1;
                    mem_req_d     = 1'b1;
                    mem_refresh_d = 1'b1;
                    state_d       = S_REFRESH;
                end else if (any_req) begin
                    gnt_d       = sel;
                    if (sel != 2'd0) begin
                        rr_last_d = sel;
                    end
                    mem_req_d   = 1'b1;
                    mem_we_d    = sel_we;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    mem_be_d    = sel_be;
                    state_d     = S_XFER;
                end
            end
            S_XFER: begin
                if (mem_done) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = S_DONE;
                end
            end
            S_REFRESH: begin
                if (mem_done) begin
                    mem_req_d     = 1'b0;
                    mem_refresh_d = 1'b0;
                    state_d       = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A wrap in the grant cycle re-arms the request instead of being lost,
        // and is not a miss because the old request was just served.
        pend_d = wrap ? 1'b1 : (refresh_grant ? 1'b0 : pend_q);
        miss_d = miss_q | (wrap & pend_q & ~refresh_grant);
    end

    always_ff @(posedge m_clock or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            pend_q        <= 1'b0;
            miss_q        <= 1'b0;
            rr_last_q     <= 2'd2;
            gnt_q         <= 2'd0;
            mem_req_q     <= 1'b0;
            mem_refresh_q <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_be_q      <= '0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            pend_q        <= pend_d;
            miss_q        <= miss_d;
            rr_last_q     <= rr_last_d;
            gnt_q         <= gnt_d;
            mem_req_q     <= mem_req_d;
            mem_refresh_q <= mem_refresh_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_be_q      <= mem_be_d;
            rdata_q       <= rdata_d;
        end
    end

    assign c0_done      = (state_q == S_DONE) && (gnt_q == 2'd0);
    assign c1_done      = (state_q == S_DONE) && (gnt_q == 2'd1);
    assign c2_done      = (state_q == S_DONE) && (gnt_q == 2'd2);
    assign rdata        = rdata_q;
    assign mem_req      = mem_req_q;
    assign mem_refresh  = mem_refresh_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_be       = mem_be_q;
    assign refresh_miss = miss_q;

endmodule
